wb_commit_unit: RTL
===================

// Module: wb_commit_unit
// PURPOSE
//  Write-back commit queue for the pipelined MIPS core. It is the producer side of the register file write port.
//  Accepts completed results from the MEM stage: ALU results carry their data, loads receive data later from dmem.
//  Buffers results in program order and retires one per cycle onto i_RegWrite/i_WriteReg/i_WriteData of the register file.
//  Exports a pending-destination mask so decode can stall on RAW hazards against uncommitted writes.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >= 2
//  DATA_W  32  result/register width
//  ADDR_W  5   register index width (32 GPRs)
// PORTS
//  i_Clk           in   1       clock; all state updates on posedge
//  i_reset_n       in   1       asynchronous, active-low reset
//  i_Valid         in   1       MEM stage presents a result this cycle
//  i_IsLoad        in   1       1 = load; data arrives later on i_MemRespData
//  i_DestReg       in   ADDR_W  destination register
//  i_AluResult     in   DATA_W  result data; ignored when i_IsLoad=1
//  o_Ready         out  1       queue can accept; transfer on i_Valid && o_Ready
//  i_MemRespValid  in   1       dmem load data valid (responses in load order)
//  i_MemRespData   in   DATA_W  dmem load data
//  o_RegWrite      out  1       register-file write enable, one-cycle pulse
//  o_WriteReg      out  ADDR_W  register-file write index
//  o_WriteData     out  DATA_W  register-file write data
//  o_PendingMask   out  32      bit d = 1 while an uncommitted write to reg d is queued
//  o_Stalled       out  1       head entry is a load still awaiting data
//  o_Error         out  1       sticky: memory response with no unfilled load queued
// BEHAVIOUR
//  Reset (async, while i_reset_n=0): queue empty and pointers 0.
//   o_RegWrite=0, o_WriteReg=0, o_WriteData=0, o_Error=0, o_Stalled=0, o_PendingMask=0, o_Ready=1.
//  Entry = {is_load, dest, data, data_ok}. Enqueue sets data_ok = ~i_IsLoad.
//  o_Ready = (count < DEPTH), from registered count only.
//   Full with a pop in the same cycle still refuses the push.
//  Load fill: i_MemRespValid writes data into the oldest queued entry with is_load && !data_ok, then sets data_ok.
//   Use a dedicated fill pointer.
//   A load enqueued in the same cycle is not eligible.
//   With no eligible entry: drop the response and set o_Error (held until reset).
//  Head FSM, evaluated on registered queue state:
//   EMPTY: count==0. Go to COMMIT on the first push.
//   COMMIT: head data_ok. Pop the head; outputs registered next edge. Stay while the next head is ready.
//           Go to WAIT_LOAD if the next head is an unfilled load; go to EMPTY if the queue drains.
//   WAIT_LOAD: head is a load with !data_ok; o_Stalled=1.
//              Go to COMMIT on the edge where the fill lands (commit on the following edge).
//  Commit outputs: registered. o_RegWrite=1 for exactly one cycle per popped entry with dest!=0.
//   o_WriteReg/o_WriteData hold the last committed values when o_RegWrite=0.
//   Registered outputs are stable across the register file's negedge write.
//  dest==0 entries are popped normally but never assert o_RegWrite.
//  Latency:
//   ALU push into empty queue at edge N -> o_RegWrite high during cycle N+1..N+2.
//   Load data fill at edge M while at head -> o_RegWrite high after edge M+1.
//  Throughput: one commit per cycle. Push, fill and pop may all occur in the same cycle.
//  o_PendingMask: combinational OR of one-hot(dest) over all occupied entries; bit 0 forced 0.
//   The bit clears in the same cycle o_RegWrite rises for the last queued write to that reg.
//  Ordering: commits strictly in enqueue order. A later ALU result never bypasses an earlier unfilled load.
//  Pointers wrap modulo DEPTH. count is ADDR-independent, width clog2(DEPTH)+1.
//  Reset mid-operation: queued entries discarded, no partial write. o_RegWrite drops immediately (async).
// TESTING
//  1. Push ALU {r5,0x1234} into empty queue -> 1 cycle later o_RegWrite=1, o_WriteReg=5, o_WriteData=0x1234.
//     o_PendingMask[5] set for exactly 1 cycle.
//  2. Push load r8, then ALU {r9,0xBEEF}; resp 0xCAFE 3 cycles later.
//     -> o_Stalled=1 until the fill; commits r8=0xCAFE then r9=0xBEEF on consecutive cycles.
//  3. Push DEPTH+1 ALU results back-to-back with no loads.
//     -> o_Ready=0 exactly while count==DEPTH; no result lost or reordered.
//  4. Push ALU {r0,0xFFFF} -> no o_RegWrite pulse; o_PendingMask stays 0.
//  5. i_MemRespValid with no load queued -> o_Error=1 and stays set; the queue is unaffected.
//  6. Assert i_reset_n=0 mid-drain with 3 entries queued -> outputs zero immediately.
//     No further writes occur after release.

Source files
------------

// File: rtl/wb_commit_unit_if.sv
// Bundles the MEM-stage result handshake, dmem load response and register-file write port of the commit queue.
interface wb_commit_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_Valid;
  logic              i_IsLoad;
  logic [ADDR_W-1:0] i_DestReg;
  logic [DATA_W-1:0] i_AluResult;
  logic              o_Ready;
  logic              i_MemRespValid;
  logic [DATA_W-1:0] i_MemRespData;
  logic              o_RegWrite;
  logic [ADDR_W-1:0] o_WriteReg;
  logic [DATA_W-1:0] o_WriteData;
  logic [31:0]       o_PendingMask;
  logic              o_Stalled;
  logic              o_Error;

  modport master (
    output i_Valid, i_IsLoad, i_DestReg, i_AluResult, i_MemRespValid, i_MemRespData,
    input  o_Ready, o_RegWrite, o_WriteReg, o_WriteData, o_PendingMask, o_Stalled, o_Error
  );

  modport slave (
    input  i_Valid, i_IsLoad, i_DestReg, i_AluResult, i_MemRespValid, i_MemRespData,
    output o_Ready, o_RegWrite, o_WriteReg, o_WriteData, o_PendingMask, o_Stalled, o_Error
  );
endinterface

// File: rtl/wb_commit_unit.sv
// In-order write-back commit queue: buffers MEM-stage results, fills loads from dmem in order,
// retires one entry per cycle to the register file and publishes a pending-destination mask.
module wb_commit_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            i_Clk,
  input logic            i_reset_n,
  wb_commit_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {EMPTY, COMMIT, WAIT_LOAD} headState_t;

  headState_t        state, nextState;
  logic              isLoadQ [DEPTH];
  logic              okQ     [DEPTH];
  logic [ADDR_W-1:0] destQ   [DEPTH];
  logic [DATA_W-1:0] dataQ   [DEPTH];
  logic [PTR_W-1:0]  headPtr, tailPtr, fillPtr, fillIdx, nextHead, scanIdx, scanOff, occOff;
  logic [CNT_W-1:0]  count, remaining, nextCount;
  logic              push, pop, fill, fillFound, errorQ;
  logic              regWriteQ;
  logic [ADDR_W-1:0] writeRegQ;
  logic [DATA_W-1:0] writeDataQ;
  logic [31:0]       pendMask;

  assign bus.o_Ready = (count < CNT_W'(DEPTH));
  assign push        = bus.i_Valid && bus.o_Ready;
  assign pop         = (state == COMMIT);
  assign fill        = bus.i_MemRespValid && fillFound;

  // Search forward from the fill pointer for the oldest queued load still waiting for data.
  always_comb begin
    fillFound = 1'b0;
    fillIdx   = fillPtr;
    scanIdx   = '0;
    scanOff   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = fillPtr + PTR_W'(i);
      scanOff = scanIdx - headPtr;
      if (!fillFound && ({1'b0, scanOff} < count) && isLoadQ[scanIdx] && !okQ[scanIdx]) begin
        fillFound = 1'b1;
        fillIdx   = scanIdx;
      end
    end
  end

  always_comb begin
    pendMask = '0;
    occOff   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      occOff = PTR_W'(j) - headPtr;
      if ({1'b0, occOff} < count) pendMask = pendMask | (32'b1 << destQ[j]);
    end
    pendMask[0] = 1'b0;
  end

  // Next head state looks at the queue as it will be after this edge, including a fill landing on the new head.
  always_comb begin
    remaining = count - CNT_W'(pop);
    nextCount = remaining + CNT_W'(push);
    nextHead  = headPtr + PTR_W'(pop);
    nextState = state;
    if (nextCount == '0)
      nextState = EMPTY;
    else if (remaining == '0)
      nextState = bus.i_IsLoad ? WAIT_LOAD : COMMIT;
    else if (okQ[nextHead] || (fill && (fillIdx == nextHead)))
      nextState = COMMIT;
    else
      nextState = WAIT_LOAD;
  end

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= EMPTY;
    else            state <= nextState;
  end

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        isLoadQ[k] <= 1'b0;
        okQ[k]     <= 1'b1;
        destQ[k]   <= '0;
        dataQ[k]   <= '0;
      end
      headPtr <= '0;
      tailPtr <= '0;
      fillPtr <= '0;
      count   <= '0;
      errorQ  <= 1'b0;
    end else begin
      if (push) begin
        isLoadQ[tailPtr] <= bus.i_IsLoad;
        okQ[tailPtr]     <= !bus.i_IsLoad;
        destQ[tailPtr]   <= bus.i_DestReg;
        dataQ[tailPtr]   <= bus.i_IsLoad ? '0 : bus.i_AluResult;
        tailPtr          <= tailPtr + 1'b1;
      end
      // The fill pointer never trails the head, so it follows a pop that retires the entry it sits on.
      if (fill) begin
        dataQ[fillIdx] <= bus.i_MemRespData;
        okQ[fillIdx]   <= 1'b1;
        fillPtr        <= fillIdx + 1'b1;
      end else if (pop && (fillPtr == headPtr)) begin
        fillPtr <= headPtr + 1'b1;
      end
      if (pop) headPtr <= headPtr + 1'b1;
      count <= nextCount;
      if (bus.i_MemRespValid && !fillFound) errorQ <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else begin
      regWriteQ <= pop && (destQ[headPtr] != '0);
      if (pop && (destQ[headPtr] != '0)) begin
        writeRegQ  <= destQ[headPtr];
        writeDataQ <= dataQ[headPtr];
      end
    end
  end

  assign bus.o_RegWrite    = regWriteQ;
  assign bus.o_WriteReg    = writeRegQ;
  assign bus.o_WriteData   = writeDataQ;
  assign bus.o_PendingMask = pendMask;
  assign bus.o_Stalled     = (state == WAIT_LOAD);
  assign bus.o_Error       = errorQ;
endmodule
